// File: rtl/uart_apb_bridge.sv
// APB3 completer issuing exactly one registered access cycle on the UART regfile port per transfer.
// Setup at T, register access at T+1, PREADY at T+2+WAIT_CYCLES; dropping psel aborts without PREADY.
module uart_apb_bridge #(
  parameter int          ADDR_W      = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] WR_MASK     = 32'hFFFF_FFFF,
  parameter logic [31:0] RD_MASK     = 32'hFFFF_FFFF,
  parameter logic [4:0]  IDLE_RADDR  = 5'h1F
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic              reg_we_o,
  output logic [4:0]        reg_waddr_o,
  output logic [31:0]       reg_wdata_o,
  output logic [4:0]        reg_raddr_o,
  input  logic [31:0]       reg_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_d;
  logic        wr_q, err_q;
  logic [31:0] rbuf_q;
  logic [3:0]  cnt_q;

  logic        setup, setup_err, wait_done;
  logic [4:0]  pidx;
  logic [31:0] mask;

  logic        we_d, rdy_d, slverr_d;
  logic [4:0]  waddr_d, raddr_d;
  logic [31:0] wdata_d, prdata_d, rd_src;

  assign setup     = psel_i && !penable_i;
  assign pidx      = paddr_i[6:2];
  assign mask      = pwrite_i ? WR_MASK : RD_MASK;
  assign setup_err = (paddr_i[1:0] != 2'b00) || ((paddr_i >> 7) != '0) || !mask[pidx];
  assign wait_done = (cnt_q == WAIT_LAST);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (setup) state_d = ACCESS;
      ACCESS:  if (!psel_i)              state_d = IDLE;
               else if (WAIT_CYCLES > 0) state_d = WAIT;
               else                      state_d = RESP;
      WAIT:    if (!psel_i)        state_d = IDLE;
               else if (wait_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ACCESS is only entered from IDLE, so the access cycle is decoded straight from the setup-phase inputs.
  always_comb begin
    we_d     = (state_d == ACCESS) && !setup_err && pwrite_i;
    raddr_d  = ((state_d == ACCESS) && !setup_err && !pwrite_i) ? pidx : IDLE_RADDR;
    waddr_d  = we_d ? pidx : reg_waddr_o;
    wdata_d  = we_d ? pwdata_i : reg_wdata_o;
    rd_src   = (state == ACCESS) ? reg_rdata_i : rbuf_q;
    rdy_d    = (state_d == RESP);
    slverr_d = rdy_d && err_q;
    prdata_d = (rdy_d && !err_q && !wr_q) ? rd_src : 32'h0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pready_o    <= 1'b0;
      pslverr_o   <= 1'b0;
      prdata_o    <= 32'h0;
      reg_we_o    <= 1'b0;
      reg_waddr_o <= 5'h0;
      reg_wdata_o <= 32'h0;
      reg_raddr_o <= IDLE_RADDR;
    end else begin
      pready_o    <= rdy_d;
      pslverr_o   <= slverr_d;
      prdata_o    <= prdata_d;
      reg_we_o    <= we_d;
      reg_waddr_o <= waddr_d;
      reg_wdata_o <= wdata_d;
      reg_raddr_o <= raddr_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
      rbuf_q <= 32'h0;
      cnt_q  <= 4'h0;
    end else begin
      if (state == IDLE && setup) begin
        wr_q  <= pwrite_i;
        err_q <= setup_err;
      end
      if (state == ACCESS && !err_q && !wr_q) rbuf_q <= reg_rdata_i;
      if (state == WAIT && !wait_done) cnt_q <= cnt_q + 4'h1;
      else                             cnt_q <= 4'h0;
    end
  end

endmodule

// File: tb/tb_uart_apb_bridge.sv
// Bench: two bridges (no wait / 3 wait cycles) against a cycle-indexed expectation table built from transfer timing rules.
module tb_uart_apb_bridge;
  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel[2], pen[2], pwr[2];
  logic [7:0]  paddr[2];
  logic [31:0] pwdata[2], prdata[2], wdata[2], rdata[2];
  logic        rdy[2], serr[2], we[2];
  logic [4:0]  waddr[2], raddr[2];

  int cyc = 0;
  int errors = 0, checks = 0;

  bit          e_we[2][N], e_rdy[2][N], e_err[2][N];
  logic [4:0]  e_wa[2][N], e_ra[2][N];
  logic [31:0] e_wd[2][N], e_rd[2][N];

  int          we_cnt[2], rp_cnt[2], last_rdy[2];
  logic [4:0]  last_wa[2];
  logic [31:0] last_wd[2], last_prd[2];
  bit          last_err[2];

  function automatic logic [31:0] rf(input logic [4:0] i);
    if (i == 5'd3) return 32'h1234_5678;
    return ({27'h0, i} * 32'h0101_0101) ^ 32'hC0DE_0000;
  endfunction

  function automatic int wcy(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] wrm(input int d);
    return (d == 0) ? 32'hFFFF_FFFB : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rdm(input int d);
    return (d == 0) ? 32'hFFFF_FF7F : 32'hFFFF_FFFF;
  endfunction

  uart_apb_bridge #(.ADDR_W(8), .WAIT_CYCLES(0), .WR_MASK(32'hFFFF_FFFB), .RD_MASK(32'hFFFF_FF7F),
                    .IDLE_RADDR(5'h1F)) dut0 (
    .clk_i(clk), .reset_i(rst), .psel_i(psel[0]), .penable_i(pen[0]), .pwrite_i(pwr[0]),
    .paddr_i(paddr[0]), .pwdata_i(pwdata[0]), .prdata_o(prdata[0]), .pready_o(rdy[0]),
    .pslverr_o(serr[0]), .reg_we_o(we[0]), .reg_waddr_o(waddr[0]), .reg_wdata_o(wdata[0]),
    .reg_raddr_o(raddr[0]), .reg_rdata_i(rdata[0]));

  uart_apb_bridge #(.ADDR_W(8), .WAIT_CYCLES(3), .WR_MASK(32'hFFFF_FFFF), .RD_MASK(32'hFFFF_FFFF),
                    .IDLE_RADDR(5'h1F)) dut3 (
    .clk_i(clk), .reset_i(rst), .psel_i(psel[1]), .penable_i(pen[1]), .pwrite_i(pwr[1]),
    .paddr_i(paddr[1]), .pwdata_i(pwdata[1]), .prdata_o(prdata[1]), .pready_o(rdy[1]),
    .pslverr_o(serr[1]), .reg_we_o(we[1]), .reg_waddr_o(waddr[1]), .reg_wdata_o(wdata[1]),
    .reg_raddr_o(raddr[1]), .reg_rdata_i(rdata[1]));

  assign rdata[0] = rf(raddr[0]);
  assign rdata[1] = rf(raddr[1]);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", nm, d, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < N) begin
      for (int d = 0; d < 2; d++) begin
        chk(d, "reg_we", {31'h0, we[d]}, {31'h0, e_we[d][cyc]});
        if (e_we[d][cyc]) begin
          chk(d, "reg_waddr", {27'h0, waddr[d]}, {27'h0, e_wa[d][cyc]});
          chk(d, "reg_wdata", wdata[d], e_wd[d][cyc]);
        end
        chk(d, "reg_raddr", {27'h0, raddr[d]}, {27'h0, e_ra[d][cyc]});
        chk(d, "pready", {31'h0, rdy[d]}, {31'h0, e_rdy[d][cyc]});
        chk(d, "pslverr", {31'h0, serr[d]}, {31'h0, e_err[d][cyc]});
        chk(d, "prdata", prdata[d], e_rd[d][cyc]);
        if (we[d] === 1'b1) begin
          we_cnt[d]++; last_wa[d] = waddr[d]; last_wd[d] = wdata[d];
        end
        if (raddr[d] !== 5'h1F) rp_cnt[d]++;
        if (rdy[d] === 1'b1) begin
          last_rdy[d] = cyc; last_prd[d] = prdata[d]; last_err[d] = serr[d];
        end
      end
    end
  end

  // Transfer rules: access at T+1, response at T+2+W unless psel drops during access/wait.
  task automatic expect_xfer(input int d, input int t, input bit wr, input logic [7:0] a,
                             input logic [31:0] dat, input int abort_k);
    logic [4:0]  idx;
    logic [31:0] m;
    bit          err;
    idx = a[6:2];
    m   = wr ? wrm(d) : rdm(d);
    err = (a[1:0] != 2'b00) || a[7] || !m[idx];
    if (!err && wr) begin
      e_we[d][t+1] = 1'b1; e_wa[d][t+1] = idx; e_wd[d][t+1] = dat;
    end
    if (!err && !wr) e_ra[d][t+1] = idx;
    if (abort_k == 0) begin
      e_rdy[d][t+2+wcy(d)] = 1'b1;
      e_err[d][t+2+wcy(d)] = err;
      e_rd[d][t+2+wcy(d)]  = (!err && !wr) ? rf(idx) : 32'h0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin psel[d] = 1'b0; pen[d] = 1'b0; end
    end
  endtask

  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] dat,
                      input int abort_k, output int t);
    tick();
    t = cyc;
    expect_xfer(d, t, wr, a, dat, abort_k);
    psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr; paddr[d] = a; pwdata[d] = dat;
    for (int k = 1; k <= 2 + wcy(d); k++) begin
      tick();
      if (k == abort_k) begin
        psel[d] = 1'b0; pen[d] = 1'b0;
        break;
      end
      pen[d] = 1'b1; pwr[d] = ~wr; paddr[d] = a ^ 8'h5C; pwdata[d] = ~dat;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, w0, r0, lr;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; pen[d] = 0; pwr[d] = 0; paddr[d] = 0; pwdata[d] = 0;
      we_cnt[d] = 0; rp_cnt[d] = 0; last_rdy[d] = -1; last_wa[d] = 0; last_wd[d] = 0;
      last_prd[d] = 0; last_err[d] = 0;
      for (int c = 0; c < N; c++) begin
        e_we[d][c] = 0; e_rdy[d][c] = 0; e_err[d][c] = 0; e_wa[d][c] = 0;
        e_ra[d][c] = 5'h1F; e_wd[d][c] = 0; e_rd[d][c] = 0;
      end
    end
    tick(); tick();
    chk(0, "reset_raddr", {27'h0, raddr[0]}, 32'h1F);
    chk(1, "reset_pready", {31'h0, rdy[1]}, 32'h0);
    chk(0, "reset_prdata", prdata[0], 32'h0);
    tick(); rst = 1'b0;
    idle(1);

    w0 = we_cnt[0];
    xfer(0, 1'b1, 8'h04, 32'h0000_00A5, 0, t); idle(1);
    chk(0, "wr_pulses", we_cnt[0] - w0, 1);
    chk(0, "wr_waddr", {27'h0, last_wa[0]}, 32'h1);
    chk(0, "wr_wdata", last_wd[0], 32'hA5);
    chk(0, "wr_ready_cyc", last_rdy[0], t + 2);
    chk(0, "wr_slverr", {31'h0, last_err[0]}, 32'h0);

    r0 = rp_cnt[0];
    xfer(0, 1'b0, 8'h0C, 32'h0, 0, t); idle(1);
    chk(0, "rd_pulses", rp_cnt[0] - r0, 1);
    chk(0, "rd_prdata", last_prd[0], 32'h1234_5678);
    chk(0, "rd_ready_cyc", last_rdy[0], t + 2);

    w0 = we_cnt[0]; r0 = rp_cnt[0];
    xfer(0, 1'b0, 8'h05, 32'h0, 0, t); idle(1);
    chk(0, "misalign_err", {31'h0, last_err[0]}, 32'h1);
    xfer(0, 1'b1, 8'h08, 32'hDEAD_0008, 0, t); idle(1);
    chk(0, "wrmask_err", {31'h0, last_err[0]}, 32'h1);
    xfer(0, 1'b0, 8'h1C, 32'h0, 0, t);
    xfer(0, 1'b1, 8'h84, 32'h0000_0084, 0, t); idle(1);
    chk(0, "hiaddr_err", {31'h0, last_err[0]}, 32'h1);
    chk(0, "err_no_we", we_cnt[0] - w0, 0);
    chk(0, "err_no_raddr", rp_cnt[0] - r0, 0);

    xfer(0, 1'b1, 8'h10, 32'h5555_AAAA, 0, t);
    xfer(0, 1'b0, 8'h10, 32'h0, 0, t);
    idle(2);

    w0 = we_cnt[0];
    tick(); psel[0] = 1'b1; pen[0] = 1'b1; pwr[0] = 1'b1; paddr[0] = 8'h04;
    tick(); tick();
    idle(2);
    chk(0, "violation_no_we", we_cnt[0] - w0, 0);

    w0 = we_cnt[0]; lr = last_rdy[0];
    xfer(0, 1'b1, 8'h14, 32'h0000_1414, 1, t); idle(2);
    chk(0, "abort_acc_we", we_cnt[0] - w0, 1);
    chk(0, "abort_acc_nordy", last_rdy[0], lr);

    r0 = rp_cnt[1];
    xfer(1, 1'b0, 8'h00, 32'h0, 0, t);
    xfer(1, 1'b0, 8'h18, 32'h0, 0, t);
    xfer(1, 1'b0, 8'h0C, 32'h0, 0, t); idle(1);
    chk(1, "b2b_pulses", rp_cnt[1] - r0, 3);
    chk(1, "b2b_ready_cyc", last_rdy[1], t + 5);
    chk(1, "b2b_prdata", last_prd[1], 32'h1234_5678);

    w0 = we_cnt[1]; lr = last_rdy[1];
    xfer(1, 1'b1, 8'h20, 32'h0000_2020, 3, t); idle(2);
    chk(1, "abort_wait_we", we_cnt[1] - w0, 1);
    chk(1, "abort_wait_nordy", last_rdy[1], lr);
    xfer(1, 1'b1, 8'h24, 32'h0000_2424, 0, t); idle(1);
    chk(1, "after_abort_rdy", last_rdy[1], t + 5);

    tick(); psel[1] = 1'b1; pen[1] = 1'b0; pwr[1] = 1'b0; paddr[1] = 8'h0C;
    tick(); pen[1] = 1'b1; rst = 1'b1;
    #1;
    chk(1, "rst_async_raddr", {27'h0, raddr[1]}, 32'h1F);
    chk(1, "rst_async_rdy", {31'h0, rdy[1]}, 32'h0);
    psel[1] = 1'b0; pen[1] = 1'b0;
    tick(); rst = 1'b0;
    w0 = we_cnt[1];
    xfer(1, 1'b1, 8'h08, 32'hCAFE_0008, 0, t); idle(1);
    chk(1, "post_rst_we", we_cnt[1] - w0, 1);
    chk(1, "post_rst_waddr", {27'h0, last_wa[1]}, 32'h2);
    chk(1, "post_rst_rdy", last_rdy[1], t + 5);

    w0 = we_cnt[0];
    tick(); psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1; paddr[0] = 8'h04; pwdata[0] = 32'h77;
    #2; rst = 1'b1;
    tick(); psel[0] = 1'b0; rst = 1'b0;
    idle(3);
    chk(0, "pending_wr_dropped", we_cnt[0] - w0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
